// File: rtl/axis_bram_adapter_v1_0_pad.sv
// axis_bram_adapter_v1_0_pad
//   Stream conditioner placed ahead of the AXIS-to-BRAM adapter. Forwards a
//   packet word by word and zero-pads its last partial BRAM line to a full
//   line of BRAM_WIDTH_IN_WORD words. A packet longer than 2^BRAM_ADDR_LENGTH
//   lines is cut at the line boundary and the rest of it is discarded.
// Ports
//   clk, rstn           : clock, synchronous active-low reset
//   s_axis_*            : input stream (tdata/tvalid/tlast/tready)
//   m_axis_*            : registered, line-aligned output stream
//   line_count          : lines-1 of the most recently completed packet
//   pkt_done            : one-cycle pulse, coincident with the final beat
//   overflow            : sticky, set when a packet was truncated
module axis_bram_adapter_v1_0_pad #(
  parameter int DATA_WIDTH         = 32,
  parameter int BRAM_WIDTH_IN_WORD = 36,
  parameter int BRAM_ADDR_LENGTH   = 9
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [BRAM_ADDR_LENGTH-1:0] line_count,
  output logic                        pkt_done,
  output logic                        overflow
);

  localparam int WCW = (BRAM_WIDTH_IN_WORD > 1) ? $clog2(BRAM_WIDTH_IN_WORD) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(BRAM_WIDTH_IN_WORD - 1);

  typedef enum logic [1:0] {S_PASS, S_PAD, S_DROP} state_t;

  state_t                      r_state, w_next;
  logic [WCW-1:0]              r_word_cnt;
  logic [BRAM_ADDR_LENGTH-1:0] r_line_cnt;
  logic [DATA_WIDTH-1:0]       r_tdata;
  logic                        r_tvalid, r_tlast;
  logic [BRAM_ADDR_LENGTH-1:0] r_line_count;
  logic                        r_pkt_done, r_overflow;

  logic                        w_slot_free, w_word_last, w_line_last;
  logic                        w_tready, w_load, w_load_last, w_finish, w_set_ovf;
  logic [DATA_WIDTH-1:0]       w_load_data;

  assign w_slot_free = !r_tvalid || m_axis_tready;
  assign w_word_last = (r_word_cnt == WLAST);
  assign w_line_last = &r_line_cnt;

  // state register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_PASS;
    else       r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_PASS: begin
        if (w_set_ovf)                                      w_next = S_DROP;
        else if (w_load && s_axis_tlast && !w_word_last)    w_next = S_PAD;
      end
      S_PAD:  if (w_finish)                      w_next = S_PASS;
      S_DROP: if (s_axis_tvalid && s_axis_tlast) w_next = S_PASS;
      default:                                   w_next = S_PASS;
    endcase
  end

  // outputs / load controls
  always_comb begin
    w_tready    = 1'b0;
    w_load      = 1'b0;
    w_load_data = '0;
    w_load_last = 1'b0;
    w_finish    = 1'b0;
    w_set_ovf   = 1'b0;
    case (r_state)
      S_PASS: begin
        w_tready    = w_slot_free;
        w_load      = s_axis_tvalid && w_slot_free;
        w_load_data = s_axis_tdata;
        if (w_load && w_word_last) begin
          if (s_axis_tlast) begin
            w_load_last = 1'b1;
            w_finish    = 1'b1;
          end else if (w_line_last) begin
            // BRAM full: close the packet here and discard the remainder
            w_load_last = 1'b1;
            w_finish    = 1'b1;
            w_set_ovf   = 1'b1;
          end
        end
      end
      S_PAD: begin
        w_load      = w_slot_free;
        w_load_last = w_word_last;
        w_finish    = w_slot_free && w_word_last;
      end
      S_DROP:  w_tready = 1'b1;
      default: ;
    endcase
  end

  // output register, counters, status
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_word_cnt   <= '0;
      r_line_cnt   <= '0;
      r_line_count <= '0;
      r_pkt_done   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_load) begin
        r_tdata  <= w_load_data;
        r_tlast  <= w_load_last;
        r_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end

      if (w_finish) begin
        r_word_cnt <= '0;
        r_line_cnt <= '0;
      end else if (w_load) begin
        if (w_word_last) begin
          r_word_cnt <= '0;
          r_line_cnt <= r_line_cnt + 1'b1;
        end else begin
          r_word_cnt <= r_word_cnt + 1'b1;
        end
      end

      r_pkt_done <= w_finish;
      if (w_finish)  r_line_count <= r_line_cnt;
      if (w_set_ovf) r_overflow   <= 1'b1;
    end
  end

  assign s_axis_tready = w_tready;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign line_count    = r_line_count;
  assign pkt_done      = r_pkt_done;
  assign overflow      = r_overflow;

endmodule
